// File: rtl/kbdtoreg_pkg.sv
// Shared PS/2 definitions: scancodes, receiver FSM encoding and a
// number-row make-code to digit lookup.
package kbdtoreg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;

  // Returns {hit, value}; hit is 0 for anything that is not a number-row key.
  function automatic logic [4:0] scan_to_digit(input logic [7:0] code);
    logic [4:0] r;
    case (code)
      SC_0:    r = {1'b1, 4'd0};
      SC_1:    r = {1'b1, 4'd1};
      SC_2:    r = {1'b1, 4'd2};
      SC_3:    r = {1'b1, 4'd3};
      SC_4:    r = {1'b1, 4'd4};
      SC_5:    r = {1'b1, 4'd5};
      SC_6:    r = {1'b1, 4'd6};
      SC_7:    r = {1'b1, 4'd7};
      SC_8:    r = {1'b1, 4'd8};
      SC_9:    r = {1'b1, 4'd9};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/kbdtoreg_ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronisers, falling-edge detect,
// framing FSM with odd-parity check and an inactivity timeout.
module ps2_rx
  import kbdtoreg_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [1:0] raw_bits;
  logic [1:0] sync_bits;

  assign raw_bits = {ps2data, ps2clk};

  // Both lines idle high, so the synchronisers reset to 1.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic s0_reg;
      logic s1_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s0_reg <= 1'b1;
          s1_reg <= 1'b1;
        end else begin
          s0_reg <= raw_bits[gi];
          s1_reg <= s0_reg;
        end
      end
      assign sync_bits[gi] = s1_reg;
    end
  endgenerate

  logic      clk_prev_reg;
  logic      fall;
  logic      bit_in;
  rx_state_t state_reg;
  logic [2:0]  cnt_reg;
  logic [7:0]  shift_reg;
  logic        par_reg;
  logic [15:0] tmo_reg;
  logic [7:0]  data_reg;
  logic        data_valid_reg;
  logic        frame_err_reg;

  assign fall   = clk_prev_reg & ~sync_bits[0];
  assign bit_in = sync_bits[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_prev_reg   <= 1'b1;
      state_reg      <= IDLE;
      cnt_reg        <= 3'd0;
      shift_reg      <= 8'd0;
      par_reg        <= 1'b0;
      tmo_reg        <= 16'd0;
      data_reg       <= 8'd0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      clk_prev_reg   <= sync_bits[0];
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;

      // Abandon a stalled partial frame; the byte is simply dropped.
      if (fall) begin
        tmo_reg <= 16'd0;
      end else if (state_reg != IDLE) begin
        if (tmo_reg == TMO_LAST) begin
          state_reg <= IDLE;
          tmo_reg   <= 16'd0;
        end else begin
          tmo_reg <= tmo_reg + 16'd1;
        end
      end

      if (fall) begin
        case (state_reg)
          IDLE: begin
            if (!bit_in) begin
              state_reg <= DATA;
              cnt_reg   <= 3'd0;
            end
          end
          DATA: begin
            shift_reg <= {bit_in, shift_reg[7:1]};
            cnt_reg   <= cnt_reg + 3'd1;
            if (cnt_reg == 3'd7) state_reg <= PARITY;
          end
          PARITY: begin
            par_reg   <= bit_in;
            state_reg <= STOP;
          end
          STOP: begin
            state_reg <= IDLE;
            if (bit_in && (^{shift_reg, par_reg})) begin
              data_reg       <= shift_reg;
              data_valid_reg <= 1'b1;
            end else begin
              frame_err_reg <= 1'b1;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign data       = data_reg;
  assign data_valid = data_valid_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: rtl/kbdtoreg.sv
// PS/2 keyboard to CPU digit input: break filtering, number-row decode and a
// single-entry holding register with sticky error reporting.
module kbdtoreg
  import kbdtoreg_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic       rd,
  output logic [7:0] s,
  output logic       valid,
  output logic       err
);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;

  ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2clk     (ps2clk),
    .ps2data    (ps2data),
    .data       (rx_data),
    .data_valid (rx_valid),
    .frame_err  (rx_err)
  );

  logic       brk_reg;
  logic [7:0] s_reg;
  logic       valid_reg;
  logic       err_reg;
  logic [4:0] dec;
  logic       digit_ev;
  logic       overflow;

  assign dec = scan_to_digit(rx_data);

  // A byte following F0 is the release of a key and never becomes a digit.
  assign digit_ev = rx_valid && !brk_reg && (rx_data != SC_BREAK) &&
                    (rx_data != SC_EXT) && dec[4];
  assign overflow = digit_ev && valid_reg && !rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brk_reg   <= 1'b0;
      s_reg     <= 8'd0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      if (rx_valid) begin
        if (rx_data == SC_BREAK) brk_reg <= 1'b1;
        else if (brk_reg)        brk_reg <= 1'b0;
      end

      // A read in the same cycle frees the slot for the arriving digit.
      if (digit_ev && (!valid_reg || rd)) begin
        s_reg     <= {4'd0, dec[3:0]};
        valid_reg <= 1'b1;
      end else if (rd) begin
        valid_reg <= 1'b0;
      end

      if (rx_err || overflow) err_reg <= 1'b1;
      else if (rd)            err_reg <= 1'b0;
    end
  end

  assign s     = s_reg;
  assign valid = valid_reg;
  assign err   = err_reg;

endmodule

// File: doc/kbdtoreg.md
# kbdtoreg

PS/2 keyboard input block that feeds decimal digits into the CPU register file, the input counterpart of the register-to-VGA digit display path. It deserialises PS/2 device-to-host frames, checks framing and odd parity, filters break sequences, maps the ten number-row make codes to values 0-9, and holds one digit in a single-entry buffer until the CPU reads it. Sits between the board PS/2 pins and the CPU input port.

## Interface

Parameters:
- TIMEOUT, 50000: clk cycles without a PS/2 falling edge before a partial frame is abandoned (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock; single clock domain, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ps2clk  in  1  raw PS/2 clock; asynchronous to clk.
- ps2data  in  1  raw PS/2 data; asynchronous to clk.
- rd  in  1  CPU read strobe; consumes the held digit.
- s  out  8  held digit, zero-extended (s[7:4] = 0, s[3:0] = 0..9).
- valid  out  1  s holds an unread digit.
- err  out  1  sticky: parity, framing or overflow error since the last rd.

## Operation

- ps2clk and ps2data each pass through a 2-flop synchroniser; a falling edge is synced ps2clk 1 -> 0 between consecutive cycles. ps2data is sampled on that edge.
- Frame: start (0), 8 data bits LSB first, odd parity, stop (1).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on edge with data 0 -> DATA, bit count 0; edge with data 1 ignored.
  - DATA: shift data in on each edge; after the 8th bit -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: on edge -> IDLE; frame good if stop = 1 and the ones count over 8 data + parity is odd.
- Bad frame (parity or stop wrong): set err, discard byte, do not change break flag.
- Timeout: in any non-IDLE state, TIMEOUT cycles without an edge -> IDLE, partial byte discarded, err unchanged.
- Good byte handling:
  - 0xF0: set break flag, no output.
  - Break flag set: discard byte, clear break flag.
  - 0xE0 and all non-digit codes: ignored.
  - Digits: 0x45->0, 0x16->1, 0x1E->2, 0x26->3, 0x25->4, 0x2E->5, 0x36->6, 0x3D->7, 0x3E->8, 0x46->9.
- Digit buffer: a digit arriving with valid = 0 loads s and sets valid. With valid = 1 and no rd the new digit is dropped, s is kept and err is set (overflow).
- rd with valid = 1: clears valid and err. rd with valid = 0: clears err only.
- rd in the same cycle as a new digit: the new digit loads and valid stays 1.
- Reset, including mid-frame: FSM IDLE, break flag 0, counters 0, s = 0x00, valid = 0, err = 0, synchronisers to 1 (bus idle).

## Timing

- Edge detect latency: 2 cycles after the raw ps2clk fall (synchroniser), plus 1 cycle to register the edge.
- valid rises on the cycle after the stop-bit edge is registered; s is stable on that cycle.
- err rises on the cycle after the offending stop edge or overflow event.
- rd is sampled on the clk edge. valid falls on the next cycle.
- Outputs are registered; there are no combinational paths from inputs to outputs.
- The timeout counter resets on every edge and is 16 bits wide. It is sized so TIMEOUT fits; TIMEOUT = 0 is not supported.

## Structure

- Shared package: PS/2 scancode constants (10 digit codes, 0xF0, 0xE0), FSM state encoding, and a digit-code-to-value function also usable by other input blocks.
- One sub-module: ps2_rx. It contains the synchronisers, edge detect, FSM, parity and timeout. Its outputs are a byte plus a one-cycle strobe, a one-cycle frame-error strobe, and the clk/reset ports.
- The top level holds the break filter, the digit map and the holding register.

## Test plan

- Make code 0x16 with correct framing, then rd: s = 0x01 and valid = 1 on the cycle after stop; valid = 0 the cycle after rd.
- Sequence 0x45, then F0 45 without rd between: s = 0x00 and valid = 1; the break pair yields no new digit; err = 0.
- Frame 0x26 with parity bit inverted: valid stays 0, err = 1; a subsequent rd clears err.
- 0x1E, then 0x3E without rd: s stays 0x02, err = 1. Then rd on the cycle 0x46 completes: s = 0x09 and valid stays 1.
- Four data bits, then idle for TIMEOUT + 2 cycles, then a full 0x3D frame: s = 0x07, err = 0.
- Assert reset during the PARITY state of 0x36: all outputs are 0 at once. The next full 0x25 frame gives s = 0x04.
